// File: rtl/priority_arbiter_rr.sv
// Purpose: N-way request encoder with run-time fixed-priority or round-robin arbitration.
// Latency: 1 cycle from the sampled request vector to out_valid/dout/grant.
// Backpressure: result holds while out_valid & ~out_ready; din and mode are only sampled on load.
module priority_arbiter_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic [N-1:0] grant,
  output logic         zero,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic         load;
  logic         accept;
  logic         rr_q;       // the result currently presented was decided in round-robin mode
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] base;       // index holding highest priority for this decision
  logic [W-1:0] sh;
  logic [N-1:0] rot;
  logic [W-1:0] hi;
  logic [W:0]   sum;
  logic [W-1:0] win;
  logic         any;
  logic [N-1:0] grant_nxt;

  assign load   = ~out_valid | out_ready;
  assign accept = out_valid & out_ready;
  assign any    = |din;

  // Pointer advance on an accepted round-robin grant; the new decision made
  // on the same edge already sees the advanced pointer so grants keep rotating.
  always_comb begin
    ptr_nxt = ptr;
    if (accept && rr_q) begin
      ptr_nxt = (dout == '0) ? LAST : dout - W'(1);
    end
  end

  // Rotate the request so the highest-priority index lands on bit N-1, pick
  // the top set bit, then rotate the index back. Fixed mode is the
  // degenerate case of a pointer parked at N-1 (no rotation).
  always_comb begin
    base = mode ? ptr_nxt : LAST;
    sh   = LAST - base;
    rot  = N'(({din, din} << sh) >> N);
    hi   = '0;
    for (int i = 0; i < N; i++) begin
      if (rot[i]) hi = W'(i);
    end
    sum = {1'b0, hi} + {1'b0, base} + (W+1)'(1);
    win = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    grant_nxt = any ? (N'(1) << win) : '0;
  end

  // Output register: reset beats load; without load everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      grant     <= '0;
      zero      <= 1'b1;
      ptr       <= LAST;
      rr_q      <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
      if (load) begin
        out_valid <= any;
        zero      <= ~any;
        dout      <= any ? win : '0;
        grant     <= grant_nxt;
        rr_q      <= mode & any;
      end
    end
  end

endmodule
